// File: rtl/adder_4bit_pkg.sv
// Shared constants and a reference helper for the registered ripple-carry adder.
package adder_4bit_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Returns {carry, sum} for a WIDTH-bit unsigned add.
  // The carry lands in bit 'width' and all higher bits are zero.
  function automatic logic [32:0] add_ref(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [63:0] mask;
    logic [63:0] full;
    mask = (64'd1 << width) - 64'd1;
    full = ({32'd0, a} & mask) + ({32'd0, b} & mask);
    return full[32:0];
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell; the ripple chain in adder_4bit is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/adder_4bit.sv
// Registered unsigned ripple-carry adder with sum, carry-out and valid outputs.
// Defining ADDER4_OVF_EN adds a registered two's-complement overflow flag (ovf).
module adder_4bit
  import adder_4bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  output logic [WIDTH-1:0] out_data,
  output logic             cy,
  output logic             out_valid
`ifdef ADDER4_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a  (in_data1[i]),
      .b  (in_data2[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Data registers load only when in_valid is high, so X on idle inputs never reaches them.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      cy        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= sum;
        cy       <= carry[WIDTH];
      end
    end
  end

`ifdef ADDER4_OVF_EN
  // Signed overflow: carry into the MSB cell disagrees with carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= carry[WIDTH-1] ^ carry[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_adder_4bit.sv
// Directed-vector bench for adder_4bit with hand-computed expected results.
// Exercises the ovf output as well when ADDER4_OVF_EN is defined.
`timescale 1ns/1ps
module tb_adder_4bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data1;
  logic [3:0] in_data2;
  logic [3:0] out_data;
  logic       cy;
  logic       out_valid;
`ifdef ADDER4_OVF_EN
  logic       ovf;
`endif

  int checks_total;
  int checks_passed;

  adder_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .out_data  (out_data),
    .cy        (cy),
    .out_valid (out_valid)
`ifdef ADDER4_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive operands after the falling edge, then sample 1ns past the next rising edge.
  task automatic apply(input logic v, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    in_valid = v;
    in_data1 = a;
    in_data2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] d, input logic c, input logic v);
    check({tag, ".out_data"},  {28'd0, out_data},  {28'd0, d});
    check({tag, ".cy"},        {31'd0, cy},        {31'd0, c});
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data1 = 4'd0;
    in_data2 = 4'd0;

    #12;
    expect_out("reset_init", 4'b0000, 1'b0, 1'b0);
`ifdef ADDER4_OVF_EN
    check("reset_init.ovf", {31'd0, ovf}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    apply(1'b1, 4'b0000, 4'b0000);
    expect_out("zero", 4'b0000, 1'b0, 1'b1);

    apply(1'b1, 4'b0110, 4'b0011);
    expect_out("6p3", 4'b1001, 1'b0, 1'b1);
`ifdef ADDER4_OVF_EN
    check("6p3.ovf", {31'd0, ovf}, 32'd1);
`endif

    // Asynchronous reset well away from any clock edge, holding 1001.
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 4'b0000, 1'b0, 1'b0);
`ifdef ADDER4_OVF_EN
    check("async_reset.ovf", {31'd0, ovf}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    apply(1'b1, 4'b0111, 4'b1100);
    expect_out("7p12", 4'b0011, 1'b1, 1'b1);
`ifdef ADDER4_OVF_EN
    check("7p12.ovf", {31'd0, ovf}, 32'd0);
`endif

    apply(1'b1, 4'b1111, 4'b1111);
    expect_out("15p15", 4'b1110, 1'b1, 1'b1);
`ifdef ADDER4_OVF_EN
    check("15p15.ovf", {31'd0, ovf}, 32'd0);
`endif

    apply(1'b0, 4'b0101, 4'b0101);
    expect_out("hold", 4'b1110, 1'b1, 1'b0);

    apply(1'b0, 4'bxxxx, 4'bxxxx);
    expect_out("hold_x", 4'b1110, 1'b1, 1'b0);
`ifdef ADDER4_OVF_EN
    check("hold_x.ovf", {31'd0, ovf}, 32'd0);
`endif

    apply(1'b1, 4'b1000, 4'b1000);
    expect_out("b2b_1", 4'b0000, 1'b1, 1'b1);
`ifdef ADDER4_OVF_EN
    check("b2b_1.ovf", {31'd0, ovf}, 32'd1);
`endif
    apply(1'b1, 4'b0001, 4'b0001);
    expect_out("b2b_2", 4'b0010, 1'b0, 1'b1);

    apply(1'b1, 4'b1010, 4'b0101);
    expect_out("10p5", 4'b1111, 1'b0, 1'b1);

    apply(1'b0, 4'b0000, 4'b0000);
    expect_out("idle_end", 4'b1111, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
